instr_assemble: RTL and testbench

- Inverse of the immediate decode path: packs an instruction type, opcode, register fields, funct fields and a 32-bit immediate into a 32-bit RV32I instruction word.
- Range-checks the immediate against its field and flags illegal requests.
- Registered valid/ready stream with a write-address generator; used by the boot/self-test loader to fill instruction memory.
- Type codes 0..4 use the same assignment as the immediate decoder: I, S, B, U, J. Code 5 is R.

---
 rtl/instr_assemble.sv | 150 +++++++++++++++
 tb/tb_instr_assemble.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_assemble.sv
`default_nettype none
// ============================================================================
//  Module      : instr_assemble
//  Description : Packs instruction type, opcode, register/funct fields and a
//                32-bit immediate into an RV32I instruction word. Illegal
//                requests are replaced by a NOP and counted. Results leave
//                through a single registered valid/ready stage, each tagged
//                with a consecutive write address for instruction memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_assemble #(
    parameter int unsigned           ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]     BASE_ADDR = '0,
    parameter int unsigned           ERR_CNT_W = 8,
    parameter logic [31:0]           NOP_WORD  = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           instr_type,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic [4:0]           rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [31:0]          imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [ADDR_W-1:0]    out_addr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // Type codes shared with the immediate decoder, plus R
    localparam logic [2:0] c_type_i = 3'd0;
    localparam logic [2:0] c_type_s = 3'd1;
    localparam logic [2:0] c_type_b = 3'd2;
    localparam logic [2:0] c_type_u = 3'd3;
    localparam logic [2:0] c_type_j = 3'd4;
    localparam logic [2:0] c_type_r = 3'd5;

    localparam logic [ERR_CNT_W-1:0] c_err_max = {ERR_CNT_W{1'b1}};

    logic                 out_valid_q, out_valid_d;
    logic [31:0]          out_instr_q, out_instr_d;
    logic [ADDR_W-1:0]    out_addr_q,  out_addr_d;
    logic                 out_err_q,   out_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q,   err_cnt_d;
    logic [ADDR_W-1:0]    next_addr_q, next_addr_d;

    logic        w_accept;
    logic [31:0] w_word;
    logic        w_legal;

    // Output register is free when empty or being drained this cycle
    assign in_ready = !out_valid_q || out_ready;
    assign w_accept = in_valid && in_ready;

    // Field packing and immediate range check for the requested format
    always_comb begin
        w_word  = 32'd0;
        w_legal = 1'b0;
        case (instr_type)
            c_type_i: begin
                w_word  = {imm[11:0], rs1, funct3, rd, opcode};
                w_legal = (&imm[31:11]) || !(|imm[31:11]);
            end
            c_type_s: begin
                w_word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                w_legal = (&imm[31:11]) || !(|imm[31:11]);
            end
            c_type_b: begin
                w_word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                w_legal = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
            end
            c_type_u: begin
                w_word  = {imm[31:12], rd, opcode};
                w_legal = !(|imm[11:0]);
            end
            c_type_j: begin
                w_word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                w_legal = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
            end
            c_type_r: begin
                w_word  = {funct7, rs2, rs1, funct3, rd, opcode};
                w_legal = 1'b1;
            end
            default: begin
                w_word  = 32'd0;
                w_legal = 1'b0;
            end
        endcase
        // Every RV32I base encoding ends in 2'b11
        if (opcode[1:0] != 2'b11) begin
            w_legal = 1'b0;
        end
    end

    // Next-state for the output stage, address generator and error counter
    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        out_err_d   = out_err_q;
        err_cnt_d   = err_cnt_q;
        next_addr_d = next_addr_q;
        if (w_accept) begin
            out_valid_d = 1'b1;
            out_instr_d = w_legal ? w_word : NOP_WORD;
            out_err_d   = !w_legal;
            out_addr_d  = next_addr_q;
            next_addr_d = next_addr_q + ADDR_W'(4);
            if (!w_legal && (err_cnt_q != c_err_max)) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_instr_q <= 32'd0;
            out_addr_q  <= BASE_ADDR;
            out_err_q   <= 1'b0;
            err_cnt_q   <= '0;
            next_addr_q <= BASE_ADDR;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            out_err_q   <= out_err_d;
            err_cnt_q   <= err_cnt_d;
            next_addr_q <= next_addr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_addr  = out_addr_q;
    assign out_err   = out_err_q;
    assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_assemble.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_assemble
//  Description : Self-checking bench for instr_assemble: directed vector
//                table, backpressure and reset sequences, and a randomized
//                run scored against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_assemble;

    localparam int          ADDR_W  = 32;
    localparam logic [31:0] BASE    = 32'h0000_1000;
    localparam int          ECW     = 8;
    localparam int          ERR_MAX = 255;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam int          NV      = 17;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        instr_type = '0;
    logic [6:0]        opcode = '0;
    logic [2:0]        funct3 = '0;
    logic [6:0]        funct7 = '0;
    logic [4:0]        rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0]       imm = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;
    logic [ECW-1:0]    err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    instr_assemble #(
        .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .ERR_CNT_W(ECW), .NOP_WORD(NOP)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr_type(instr_type), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .out_err(out_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  t;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    vec_t tbl [NV];
    exp_t sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fld(input logic [31:0] x, input int hi, input int lo);
        return (x >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
    endfunction

    // Reference: legality from signed ranges, word built by placing fields
    function automatic logic [32:0] ref_model(input logic [2:0] t, input logic [6:0] op,
                                              input logic [2:0] f3, input logic [6:0] f7,
                                              input logic [4:0] rdv, input logic [4:0] r1,
                                              input logic [4:0] r2, input logic [31:0] im);
        int          si;
        bit          ok;
        logic [31:0] w;
        logic [31:0] o, d, a, b, f;
        si = $signed(im);
        o = 32'(op); d = 32'(rdv); a = 32'(r1); b = 32'(r2); f = 32'(f3);
        w = 32'd0;
        ok = 1'b0;
        case (t)
            3'd0: begin
                ok = (si >= -2048) && (si <= 2047);
                w  = (fld(im, 11, 0) << 20) | (a << 15) | (f << 12) | (d << 7) | o;
            end
            3'd1: begin
                ok = (si >= -2048) && (si <= 2047);
                w  = (fld(im, 11, 5) << 25) | (b << 20) | (a << 15) | (f << 12)
                   | (fld(im, 4, 0) << 7) | o;
            end
            3'd2: begin
                ok = (si >= -4096) && (si <= 4095) && (si % 2 == 0);
                w  = (fld(im, 12, 12) << 31) | (fld(im, 10, 5) << 25) | (b << 20) | (a << 15)
                   | (f << 12) | (fld(im, 4, 1) << 8) | (fld(im, 11, 11) << 7) | o;
            end
            3'd3: begin
                ok = (im % 32'd4096) == 32'd0;
                w  = ((im / 32'd4096) << 12) | (d << 7) | o;
            end
            3'd4: begin
                ok = (si >= -1048576) && (si <= 1048575) && (si % 2 == 0);
                w  = (fld(im, 20, 20) << 31) | (fld(im, 10, 1) << 21) | (fld(im, 11, 11) << 20)
                   | (fld(im, 19, 12) << 12) | (d << 7) | o;
            end
            3'd5: begin
                ok = 1'b1;
                w  = (32'(f7) << 25) | (b << 20) | (a << 15) | (f << 12) | (d << 7) | o;
            end
            default: ok = 1'b0;
        endcase
        if (o % 4 != 3) ok = 1'b0;
        return {!ok, ok ? w : NOP};
    endfunction

    task automatic apply(input vec_t v);
        instr_type = v.t; opcode = v.op; funct3 = v.f3; funct7 = v.f7;
        rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_valid"},   32'(out_valid), 32'd0);
        chk({tag, "_instr"},   out_instr,      32'd0);
        chk({tag, "_err"},     32'(out_err),   32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt),   32'd0);
        chk({tag, "_addr"},    out_addr,       BASE);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rnd_imm();
        logic [31:0] r;
        case ($urandom_range(0, 5))
            0: r = $urandom;
            1: r = 32'($urandom_range(0, 8191)) - 32'd4096;
            2: begin
                case ($urandom_range(0, 9))
                    0: r = 32'd2047;        1: r = 32'd2048;
                    2: r = 32'hFFFF_F800;   3: r = 32'hFFFF_F7FF;
                    4: r = 32'd4094;        5: r = 32'd4096;
                    6: r = 32'hFFFF_F000;   7: r = 32'd1048574;
                    8: r = 32'd1048576;     default: r = 32'hFFF0_0000;
                endcase
            end
            3: r = $urandom & 32'hFFFF_F000;
            4: r = (32'($urandom_range(0, 4194303)) - 32'd2097152) & 32'hFFFF_FFFE;
            default: r = 32'($urandom_range(0, 63));
        endcase
        return r;
    endfunction

    initial begin
        int          exp_errs;
        logic [31:0] m_next;
        int          m_errs;
        logic [32:0] r;
        exp_t        e;

        //        t     op     f3    f7     rd     rs1    rs2    imm            expected      err
        tbl[0]  = '{3'd0, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5,         32'h0050_0093, 1'b0};
        tbl[1]  = '{3'd1, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,         32'h0020_A423, 1'b0};
        tbl[2]  = '{3'd4, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFFDF_F0EF, 1'b0};
        tbl[3]  = '{3'd2, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3,         NOP,           1'b1};
        tbl[4]  = '{3'd0, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_0800, NOP,           1'b1};
        tbl[5]  = '{3'd5, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'hDEAD_BEEF, 32'h0020_81B3, 1'b0};
        tbl[6]  = '{3'd3, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0};
        tbl[7]  = '{3'd2, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 32'hFE20_8CE3, 1'b0};
        tbl[8]  = '{3'd0, 7'h13, 3'd0, 7'h00, 5'd2, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'hFFF1_0113, 1'b0};
        tbl[9]  = '{3'd0, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_07FF, 32'h7FF0_0093, 1'b0};
        tbl[10] = '{3'd0, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 32'h8000_0093, 1'b0};
        tbl[11] = '{3'd0, 7'h10, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd0,         NOP,           1'b1};
        tbl[12] = '{3'd6, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd0,         NOP,           1'b1};
        tbl[13] = '{3'd3, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'd1,         NOP,           1'b1};
        tbl[14] = '{3'd4, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0010_0000, NOP,           1'b1};
        tbl[15] = '{3'd5, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0,         32'h4020_81B3, 1'b0};
        tbl[16] = '{3'd4, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFF0_0000, 32'h8000_00EF, 1'b0};

        // Directed vectors, back to back with the consumer always ready
        do_reset("rst0");
        out_ready = 1'b1;
        exp_errs = 0;
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            apply(tbl[i]);
            in_valid = 1'b1;
            #1 chk("tbl_in_ready", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            exp_errs += int'(tbl[i].exp_err);
            chk("tbl_valid",   32'(out_valid), 32'd1);
            chk("tbl_instr",   out_instr,      tbl[i].exp_instr);
            chk("tbl_err",     32'(out_err),   32'(tbl[i].exp_err));
            chk("tbl_addr",    out_addr,       BASE + 32'(4 * i));
            chk("tbl_err_cnt", 32'(err_cnt),   32'(exp_errs));
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1 chk("tbl_drain_valid", 32'(out_valid), 32'd0);

        // Backpressure: first result held for three cycles, second one waits
        do_reset("rst1");
        @(negedge clk);
        apply('{3'd0, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1, 32'd0, 1'b0});
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_first_valid", 32'(out_valid), 32'd1);
        chk("bp_first_instr", out_instr,      32'h0010_0093);
        chk("bp_in_ready",    32'(in_ready),  32'd0);
        @(negedge clk);
        apply('{3'd0, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd2, 32'd0, 1'b0});
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_instr", out_instr,     32'h0010_0093);
            chk("bp_hold_addr",  out_addr,      BASE);
            chk("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("bp_second_valid", 32'(out_valid), 32'd1);
        chk("bp_second_instr", out_instr,      32'h0020_0113);
        chk("bp_second_addr",  out_addr,       BASE + 32'd4);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1 chk("bp_empty_valid", 32'(out_valid), 32'd0);

        // Reset while an illegal result is held under backpressure
        @(negedge clk);
        apply('{3'd7, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0});
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("rh_err",     32'(out_err), 32'd1);
        chk("rh_err_cnt", 32'(err_cnt), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        chk("rh_valid_dropped", 32'(out_valid), 32'd0);
        chk("rh_err_cnt_clr",   32'(err_cnt),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        apply('{3'd0, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 32'd0, 1'b0});
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rh_next_valid", 32'(out_valid), 32'd1);
        chk("rh_next_addr",  out_addr,       BASE);
        @(negedge clk);
        in_valid = 1'b0;

        // Randomized traffic against the reference model and scoreboard
        do_reset("rst2");
        m_next = BASE;
        m_errs = 0;
        sb.delete();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            instr_type = 3'($urandom_range(0, 7));
            opcode     = ($urandom_range(0, 9) == 0) ? 7'($urandom) : {5'($urandom), 2'b11};
            funct3     = 3'($urandom);
            funct7     = 7'($urandom);
            rd         = 5'($urandom);
            rs1        = 5'($urandom);
            rs2        = 5'($urandom);
            imm        = rnd_imm();
            #1;
            chk("rnd_valid",    32'(out_valid), 32'(sb.size() != 0));
            chk("rnd_in_ready", 32'(in_ready),  32'((sb.size() == 0) || out_ready));
            chk("rnd_err_cnt",  32'(err_cnt),   32'(m_errs));
            if (out_valid && out_ready && (sb.size() != 0)) begin
                e = sb.pop_front();
                chk("rnd_instr", out_instr,    e.instr);
                chk("rnd_addr",  out_addr,     e.addr);
                chk("rnd_err",   32'(out_err), 32'(e.err));
            end
            if (in_valid && in_ready) begin
                r = ref_model(instr_type, opcode, funct3, funct7, rd, rs1, rs2, imm);
                e.instr = r[31:0];
                e.err   = r[32];
                e.addr  = m_next;
                m_next  = m_next + 32'd4;
                if (r[32] && (m_errs < ERR_MAX)) m_errs++;
                sb.push_back(e);
            end
        end
        chk("rnd_err_cnt_saturated", 32'(m_errs), 32'(ERR_MAX));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
